// File: rtl/gal_tri_bus_ctrl.sv
// gal_tri_bus_ctrl: write/read sequencer for a GAL-style registered tristate bus.
// It produces the registered data word and the output enable for the tristate cells.
// Turnaround gaps keep the bus released before and after each drive window.
// Each completed transaction ends with a one-cycle DONE pulse.
// Build option: define GAL_TRI_BUS_INV_EN when the macrocells are active-low.
// The external bus then carries inverted data, while WDATA and RDATA stay true polarity.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | bus released, waiting for WR_REQ / RD_REQ (write wins)
// TURN_ON  | bus released, gap before this block starts driving
// DRIVE    | OE high, DQ on the bus for HOLD_CYCLES cycles
// TURN_OFF | bus released, gap before another driver may take the bus
// READ     | bus released, wait HOLD_CYCLES then capture BUS into RDATA
module gal_tri_bus_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             C,
  input  logic             R,
  input  logic             WR_REQ,
  input  logic             RD_REQ,
  input  logic [WIDTH-1:0] WDATA,
  inout  wire  [WIDTH-1:0] BUS,
  output logic             OE,
  output logic [WIDTH-1:0] DQ,
  output logic [WIDTH-1:0] RDATA,
  output logic             BUSY,
  output logic             DONE
);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 7) begin : g_bad_turn
    $error("gal_tri_bus_ctrl: TURN_CYCLES must be 1..7");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 7) begin : g_bad_hold
    $error("gal_tri_bus_ctrl: HOLD_CYCLES must be 1..7");
  end

  localparam logic [2:0] TURN_LD = 3'(TURN_CYCLES - 1);
  localparam logic [2:0] HOLD_LD = 3'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TURN_ON, S_DRIVE, S_TURN_OFF, S_READ
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       count, count_nxt;
  logic [WIDTH-1:0] dq_nxt, rdata_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] wr_word, rd_word;

`ifdef GAL_TRI_BUS_INV_EN
  assign wr_word = ~WDATA;
  assign rd_word = ~BUS;
`else
  assign wr_word = WDATA;
  assign rd_word = BUS;
`endif

  // Registered drivers onto the shared bus.
  assign BUS  = OE ? DQ : 'z;
  assign BUSY = (state != S_IDLE);

  // State register and output registers; reset releases the bus at once.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state <= S_IDLE;
      count <= 3'd0;
      OE    <= 1'b0;
      DQ    <= '0;
      RDATA <= '0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      OE    <= (state_nxt == S_DRIVE);
      DQ    <= dq_nxt;
      RDATA <= rdata_nxt;
      DONE  <= done_nxt;
    end
  end

  // Next-state logic: the down-counter is reloaded on every state entry.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    dq_nxt    = DQ;
    rdata_nxt = RDATA;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (WR_REQ) begin
          dq_nxt    = wr_word;
          state_nxt = S_TURN_ON;
          count_nxt = TURN_LD;
        end else if (RD_REQ) begin
          state_nxt = S_READ;
          count_nxt = HOLD_LD;
        end
      end
      S_TURN_ON: begin
        if (count == 3'd0) begin
          state_nxt = S_DRIVE;
          count_nxt = HOLD_LD;
        end else begin
          count_nxt = count - 3'd1;
        end
      end
      S_DRIVE: begin
        if (count == 3'd0) begin
          state_nxt = S_TURN_OFF;
          count_nxt = TURN_LD;
        end else begin
          count_nxt = count - 3'd1;
        end
      end
      S_TURN_OFF: begin
        if (count == 3'd0) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          count_nxt = count - 3'd1;
        end
      end
      S_READ: begin
        if (count == 3'd0) begin
          rdata_nxt = rd_word;
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          count_nxt = count - 3'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_gal_tri_bus_ctrl.sv
// Bench for gal_tri_bus_ctrl: a timeline model plus directed literal checks and random traffic.
module tb_gal_tri_bus_ctrl;
  localparam int T = 1;
  localparam int H = 2;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] ext_data = 8'h00;
  logic       drv_ext = 1'b1;
  wire  [7:0] bus_w;
  logic       oe, busy, done;
  logic [7:0] dq, rdata;

  int checks = 0;
  int failures = 0;

  assign bus_w = drv_ext ? ext_data : 'z;

  always #5 C = ~C;

  gal_tri_bus_ctrl #(.WIDTH(8), .TURN_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .C(C), .R(R), .WR_REQ(wr), .RD_REQ(rd), .WDATA(wdata), .BUS(bus_w),
    .OE(oe), .DQ(dq), .RDATA(rdata), .BUSY(busy), .DONE(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef GAL_TRI_BUS_INV_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Timeline model: an accepted request fixes the edges of its drive window and DONE.
  int         cyc = 0;
  int         m_idle_from = 0, m_acc = -1, m_done = -1;
  int         m_oe_lo = -1, m_oe_hi = -2, m_rd_edge = -1;
  logic [7:0] m_dq = 8'h00, m_rdata = 8'h00;
  logic       e_oe = 1'b0, e_busy = 1'b0, e_done = 1'b0, model_ok = 1'b0;

  always @(posedge C) begin
    if (!R) begin
      m_idle_from = cyc + 1; m_acc = -1; m_done = -1;
      m_oe_lo = -1; m_oe_hi = -2; m_rd_edge = -1;
      m_dq = 8'h00; m_rdata = 8'h00;
      e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      model_ok = 1'b0;
    end else begin
      if (cyc == m_rd_edge) m_rdata = pol(ext_data);
      if (cyc >= m_idle_from && (wr || rd)) begin
        m_acc = cyc;
        if (wr) begin
          m_dq      = pol(wdata);
          m_oe_lo   = cyc + T;
          m_oe_hi   = cyc + T + H - 1;
          m_done    = cyc + 2 * T + H;
          m_rd_edge = -1;
        end else begin
          m_done    = cyc + H;
          m_rd_edge = cyc + H;
        end
        m_idle_from = m_done + 1;
      end
      e_busy   = (cyc >= m_acc) && (cyc < m_done);
      e_done   = (cyc == m_done);
      e_oe     = (cyc >= m_oe_lo) && (cyc <= m_oe_hi);
      model_ok = 1'b1;
    end
    drv_ext = !e_oe;
    cyc++;
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge C) begin
    if (R && model_ok) begin
      chk("oe", 32'(oe), 32'(e_oe));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("dq", 32'(dq), 32'(m_dq));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      if (e_oe) chk("bus_drive", 32'(bus_w), 32'(m_dq));
    end
  end

  task automatic step();
    @(negedge C);
    #1;
  endtask

  logic [5:0] oe_v, busy_v, done_v;
  logic [7:0] bus_j1, rd_exp;
  int         ndone, low_run, min_gap;
  bit         seen_win;

  initial begin
    // reset values
    step(); step();
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_dq", 32'(dq), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    R = 1'b1;
    step();

    // single write of A5
    wr = 1'b1; wdata = 8'hA5;
    oe_v = '0; busy_v = '0; done_v = '0; bus_j1 = 8'h00;
    for (int j = 0; j < 6; j++) begin
      step();
      oe_v[j] = oe; busy_v[j] = busy; done_v[j] = done;
      if (j == 1) bus_j1 = bus_w;
      if (j == 0) begin wr = 1'b0; wdata = 8'($urandom); end
    end
    chk("wr_oe_window", 32'(oe_v), 32'(6'b000110));
    chk("wr_busy_window", 32'(busy_v), 32'(6'b001111));
    chk("wr_done_cycle", 32'(done_v), 32'(6'b010000));
`ifdef GAL_TRI_BUS_INV_EN
    chk("wr_bus_value", 32'(bus_j1), 32'h5A);
`else
    chk("wr_bus_value", 32'(bus_j1), 32'hA5);
`endif

    // single read from an external driver
`ifdef GAL_TRI_BUS_INV_EN
    ext_data = 8'h0F; rd_exp = 8'hF0;
`else
    ext_data = 8'h3C; rd_exp = 8'h3C;
`endif
    rd = 1'b1;
    oe_v = '0; busy_v = '0; done_v = '0;
    for (int j = 0; j < 4; j++) begin
      step();
      oe_v[j] = oe; busy_v[j] = busy; done_v[j] = done;
      if (j == 0) rd = 1'b0;
    end
    chk("rd_busy_window", 32'(busy_v), 32'(6'b000011));
    chk("rd_done_cycle", 32'(done_v), 32'(6'b000100));
    chk("rd_oe_low", 32'(oe_v), 32'd0);
    chk("rd_value", 32'(rdata), 32'(rd_exp));

    // write and read together, then a read pulse while busy
    wr = 1'b1; rd = 1'b1; wdata = 8'h11;
    busy_v = '0; done_v = '0;
    for (int j = 0; j < 6; j++) begin
      step();
      busy_v[j] = busy; done_v[j] = done;
      if (j == 0) begin wr = 1'b0; rd = 1'b0; end
      if (j == 1) rd = 1'b1;
      if (j == 2) rd = 1'b0;
    end
    chk("both_busy", 32'(busy_v), 32'(6'b001111));
    chk("both_done", 32'(done_v), 32'(6'b010000));
    chk("both_rdata_kept", 32'(rdata), 32'(rd_exp));
`ifdef GAL_TRI_BUS_INV_EN
    chk("both_dq", 32'(dq), 32'hEE);
`else
    chk("both_dq", 32'(dq), 32'h11);
`endif

    // write request held high: back-to-back transactions
    wr = 1'b1; ndone = 0; low_run = 0; min_gap = 99; seen_win = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      wdata = 8'($urandom);
      if (done) ndone++;
      if (oe) begin
        if (seen_win && low_run > 0 && low_run < min_gap) min_gap = low_run;
        low_run = 0;
        seen_win = 1'b1;
      end else begin
        low_run++;
      end
    end
    wr = 1'b0;
    chk("hold_done_count", 32'(ndone), 32'd4);
    chk("hold_oe_gap_ge2", 32'(min_gap >= 2), 32'd1);
    step(); step();

    // asynchronous reset in the middle of a drive window
    wr = 1'b1; wdata = 8'hC3;
    step();
    wr = 1'b0;
    step();
    chk("pre_rst_oe", 32'(oe), 32'd1);
    #2 R = 1'b0;
    #1;
    chk("arst_oe", 32'(oe), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_dq", 32'(dq), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_rdata", 32'(rdata), 32'd0);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) ndone++;
    end
    R = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // random traffic checked by the model
    for (int i = 0; i < 600; i++) begin
      wr = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 2) == 0);
      wdata = 8'($urandom);
      ext_data = 8'($urandom);
      step();
    end
    wr = 1'b0; rd = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
